mem_width_seq: RTL and testbench

- Sequencer that splits one bus transfer of 2^sz bytes at byte offset ba into memory cycles of native width 2^mw bytes.
- For each cycle it emits the byte address, the byte-lane mask and a last-cycle flag, and it advances on memory ack.
- Generalised successor to the fixed 64-bit width splitter: bus width is parametrised, the walk is registered, back-to-back requests are accepted, and misaligned transfers are an optional feature.
- Sits between the bus arbiter and the DRAM/ROM cycle generators.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_width_mask.sv | 36 +++
 rtl/mem_width_seq.sv | 152 +++++++++++++++
 tb/tb_mem_width_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-width sequencer: size codes, walk states and the
// lane-mask helper used to turn a byte range into bus byte-lane enables.
package mem_pkg;

  localparam int unsigned SZ_BYTE   = 0;
  localparam int unsigned SZ_WORD   = 1;
  localparam int unsigned SZ_LONG   = 2;
  localparam int unsigned SZ_PHRASE = 3;

  // Widest supported bus; lane_mask works on this width and callers keep the low lanes.
  localparam int unsigned MAX_BUS_BYTES = 32;

  typedef logic [MAX_BUS_BYTES-1:0] lane_vec_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  // Lanes lo <= i < hi set; with bigend the lane order is mirrored within nbytes.
  function automatic lane_vec_t lane_mask(input int unsigned lo, input int unsigned hi,
                                          input logic bigend, input int unsigned nbytes);
    lane_vec_t   m;
    logic [4:0]  idx;
    m = '0;
    for (int unsigned i = 0; i < MAX_BUS_BYTES; i++) begin
      if ((i >= lo) && (i < hi) && (i < nbytes)) begin
        idx    = bigend ? 5'(nbytes - 1 - i) : 5'(i);
        m[idx] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_width_mask.sv
// Combinational lane arithmetic for one memory cycle: end of the current memory word
// clipped to the transfer end, the active byte lanes and the last-cycle flag.
module mem_width_mask
  import mem_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 8,
  parameter int unsigned AB        = $clog2(BUS_BYTES),
  parameter int unsigned SZW       = $clog2(AB + 1)
) (
  input  logic                 i_active,
  input  logic [AB-1:0]        i_at,
  input  logic [AB:0]          i_end,
  input  logic [SZW-1:0]       i_mw,
  input  logic                 i_bigend,
  output logic [AB:0]          o_cyc_end,
  output logic [BUS_BYTES-1:0] o_bm,
  output logic                 o_lastcycle
);

  logic [AB:0] w_mw_span;
  logic [AB:0] w_blk_end;
  lane_vec_t   w_lanes;
  logic        w_unused_lanes;

  // First byte past the memory word that holds i_at.
  assign w_mw_span = ((AB + 1)'(1) << i_mw) - (AB + 1)'(1);
  assign w_blk_end = ({1'b0, i_at} | w_mw_span) + (AB + 1)'(1);
  assign o_cyc_end = (w_blk_end < i_end) ? w_blk_end : i_end;

  assign w_lanes        = lane_mask(32'(i_at), 32'(o_cyc_end), i_bigend, BUS_BYTES);
  assign w_unused_lanes = ^w_lanes;

  assign o_bm        = i_active ? w_lanes[BUS_BYTES-1:0] : '0;
  assign o_lastcycle = i_active & (o_cyc_end == i_end);

endmodule

// File: rtl/mem_width_seq.sv
// Splits a 2^sz-byte bus transfer at offset ba into 2^mw-byte memory cycles, stepping on ack.
// Define MEMWIDTH_MISALIGN_EN to use ba unaligned instead of aligning it to the transfer size.
module mem_width_seq
  import mem_pkg::*;
#(
  parameter  int unsigned BUS_BYTES = 8,
  localparam int unsigned AB        = $clog2(BUS_BYTES),
  localparam int unsigned SZW       = $clog2(AB + 1)
) (
  input  logic                 i_sys_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [SZW-1:0]       i_sz,
  input  logic [AB-1:0]        i_ba,
  input  logic [SZW-1:0]       i_mw,
  input  logic                 i_bigend,
  input  logic                 i_ack,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic [AB-1:0]        o_at,
  output logic [BUS_BYTES-1:0] o_bm,
  output logic                 o_lastcycle,
  output logic                 o_done,
  output logic [AB:0]          o_ncyc
);

  localparam logic [SZW-1:0] AB_CODE = SZW'(AB);
  localparam logic [AB:0]    BUS_END = (AB + 1)'(BUS_BYTES);

  state_e         r_state, w_state_nxt;
  logic [AB-1:0]  r_at, w_at_nxt;
  logic [AB:0]    r_end, w_end_nxt;
  logic [SZW-1:0] r_mw, w_mw_nxt;
  logic           r_bigend, w_bigend_nxt;
  logic [AB:0]    r_ncyc, w_ncyc_nxt;
  logic           r_done, w_done_nxt;

  logic [SZW-1:0] w_sz_clamp;
  logic [SZW-1:0] w_mw_clamp;
  logic [AB:0]    w_sz_bytes;
  logic [AB-1:0]  w_ba_al;
  logic [AB:0]    w_end_raw;
  logic [AB:0]    w_end_sat;
  logic [AB:0]    w_cyc_end;
  logic           w_last;
  logic           w_busy;
  logic           w_load;

  // Request decode: clamp size codes, align the offset, clip the end to the bus window.
  assign w_sz_clamp = (i_sz > AB_CODE) ? AB_CODE : i_sz;
  assign w_mw_clamp = (i_mw > AB_CODE) ? AB_CODE : i_mw;
  assign w_sz_bytes = (AB + 1)'(1) << w_sz_clamp;

`ifdef MEMWIDTH_MISALIGN_EN
  assign w_ba_al = i_ba;
`else
  assign w_ba_al = i_ba & ~(w_sz_bytes[AB-1:0] - AB'(1));
`endif

  assign w_end_raw = {1'b0, w_ba_al} + w_sz_bytes;
  assign w_end_sat = (w_end_raw > BUS_END) ? BUS_END : w_end_raw;

  assign w_busy = (r_state == ACTIVE);

  mem_width_mask #(
    .BUS_BYTES (BUS_BYTES),
    .AB        (AB),
    .SZW       (SZW)
  ) u_mask (
    .i_active    (w_busy),
    .i_at        (r_at),
    .i_end       (r_end),
    .i_mw        (r_mw),
    .i_bigend    (r_bigend),
    .o_cyc_end   (w_cyc_end),
    .o_bm        (o_bm),
    .o_lastcycle (w_last)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_at_nxt     = r_at;
    w_end_nxt    = r_end;
    w_mw_nxt     = r_mw;
    w_bigend_nxt = r_bigend;
    w_ncyc_nxt   = r_ncyc;
    w_done_nxt   = 1'b0;
    w_load       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (i_ack) begin
          if (!w_last) begin
            w_at_nxt   = AB'(w_cyc_end);
            w_ncyc_nxt = r_ncyc + (AB + 1)'(1);
          end else begin
            // Final ack: a waiting request is taken on the same edge, no idle gap.
            w_done_nxt = 1'b1;
            if (i_start) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_state_nxt  = ACTIVE;
      w_at_nxt     = w_ba_al;
      w_end_nxt    = w_end_sat;
      w_mw_nxt     = w_mw_clamp;
      w_bigend_nxt = i_bigend;
      w_ncyc_nxt   = '0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_at     <= '0;
      r_end    <= '0;
      r_mw     <= '0;
      r_bigend <= 1'b0;
      r_ncyc   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_at     <= w_at_nxt;
      r_end    <= w_end_nxt;
      r_mw     <= w_mw_nxt;
      r_bigend <= w_bigend_nxt;
      r_ncyc   <= w_ncyc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign o_ready     = !w_busy | (i_ack & w_last);
  assign o_busy      = w_busy;
  assign o_at        = r_at;
  assign o_lastcycle = w_last;
  assign o_done      = r_done;
  assign o_ncyc      = r_ncyc;

endmodule

// File: tb/tb_mem_width_seq.sv
// Bench for mem_width_seq: a transfer-level model (list of memory cycles per request) checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_width_seq;

  localparam int BB  = 8;
  localparam int AB  = 3;
  localparam int SZW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [SZW-1:0] sz;
  logic [AB-1:0]  ba;
  logic [SZW-1:0] mw;
  logic           bigend;
  logic           ack;
  logic           ready;
  logic           busy;
  logic [AB-1:0]  at;
  logic [BB-1:0]  bm;
  logic           lastcycle;
  logic           done;
  logic [AB:0]    ncyc;

  int checks   = 0;
  int failures = 0;

  mem_width_seq #(
    .BUS_BYTES (BB)
  ) dut (
    .i_sys_clk   (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_sz        (sz),
    .i_ba        (ba),
    .i_mw        (mw),
    .i_bigend    (bigend),
    .i_ack       (ack),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_at        (at),
    .o_bm        (bm),
    .o_lastcycle (lastcycle),
    .o_done      (done),
    .o_ncyc      (ncyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each accepted request becomes a list of (address, lane mask) memory cycles.
  int m_at[BB];
  int m_bm[BB];
  int m_cnt  = 0;
  int m_idx  = 0;
  int m_ncyc = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit m_on   = 0;
  bit m_rdy;
  bit m_fin;

  function automatic void build(input int s, input int b, input int w, input bit be);
    int sbytes, wbytes, first, last_end, cur, ce, mask;
    if (s > AB) s = AB;
    if (w > AB) w = AB;
    sbytes = 1 << s;
    wbytes = 1 << w;
`ifdef MEMWIDTH_MISALIGN_EN
    first = b;
`else
    first = (b / sbytes) * sbytes;
`endif
    last_end = first + sbytes;
    if (last_end > BB) last_end = BB;
    cur   = first;
    m_cnt = 0;
    while (cur < last_end) begin
      ce = ((cur / wbytes) + 1) * wbytes;
      if (ce > last_end) ce = last_end;
      mask = 0;
      for (int i = cur; i < ce; i++) mask |= 1 << (be ? (BB - 1 - i) : i);
      m_at[m_cnt] = cur;
      m_bm[m_cnt] = mask;
      m_cnt++;
      cur = ce;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0;
      m_done = 0;
      m_ncyc = 0;
      m_on   = 1;
    end else if (m_on) begin
      m_rdy = !m_busy || (ack && (m_idx == m_cnt - 1));
      m_fin = 0;
      if (m_busy && ack) begin
        if (m_idx < m_cnt - 1) begin
          m_idx++;
          m_ncyc++;
        end else begin
          m_fin  = 1;
          m_busy = 0;
        end
      end
      if (start && m_rdy) begin
        build(int'(sz), int'(ba), int'(mw), bigend);
        m_busy = 1;
        m_idx  = 0;
        m_ncyc = 0;
      end
      m_done = m_fin;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ready", 32'(ready), 32'(!m_busy || (ack && (m_idx == m_cnt - 1))));
      chk("bm", 32'(bm), m_busy ? m_bm[m_idx] : 0);
      chk("lastcycle", 32'(lastcycle), 32'(m_busy && (m_idx == m_cnt - 1)));
      chk("done", 32'(done), 32'(m_done));
      if (m_busy) begin
        chk("at", 32'(at), m_at[m_idx]);
        chk("ncyc", 32'(ncyc), m_ncyc);
      end
    end
  end

  task automatic req(input int s, input int b, input int w, input bit be);
    sz     = SZW'(s);
    ba     = AB'(b);
    mw     = SZW'(w);
    bigend = be;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  int t1_at[4] = '{0, 2, 4, 6};
  int t1_bm[4] = '{8'h03, 8'h0C, 8'h30, 8'hC0};
`ifdef MEMWIDTH_MISALIGN_EN
  int t3_n     = 3;
  int t3_at[3] = '{3, 4, 6};
  int t3_bm[3] = '{8'h08, 8'h30, 8'h40};
`else
  int t3_n     = 2;
  int t3_at[3] = '{0, 2, 0};
  int t3_bm[3] = '{8'h03, 8'h0C, 0};
`endif

  initial begin
    reset = 1'b1; start = 1'b0; sz = '0; ba = '0; mw = '0; bigend = 1'b0; ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_at", 32'(at), 0);
    chk("rst_bm", 32'(bm), 0);
    chk("rst_last", 32'(lastcycle), 0);
    chk("rst_ncyc", 32'(ncyc), 0);
    chk("rst_ready", 32'(ready), 1);

    // 64-bit transfer over a 16-bit memory: four cycles.
    req(3, 0, 1, 0);
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t1_at", 32'(at), t1_at[k]);
      chk("t1_bm", 32'(bm), t1_bm[k]);
      chk("t1_last", 32'(lastcycle), 32'(k == 3));
      chk("t1_ncyc", 32'(ncyc), k);
      tick();
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_idle", 32'(busy), 0);
    ack = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // Big-endian long in a single phrase cycle.
    req(2, 4, 3, 1);
    chk("t2_at", 32'(at), 4);
    chk("t2_bm", 32'(bm), 8'h0F);
    chk("t2_last", 32'(lastcycle), 1);
    ack = 1'b1;
    tick();
    chk("t2_done", 32'(done), 1);
    ack = 1'b0;
    tick();

    // Odd offset: aligned or straddling depending on build.
    req(2, 3, 1, 0);
    ack = 1'b1;
    for (int k = 0; k < t3_n; k++) begin
      chk("t3_at", 32'(at), t3_at[k]);
      chk("t3_bm", 32'(bm), t3_bm[k]);
      tick();
    end
    chk("t3_done", 32'(done), 1);
    ack = 1'b0;
    tick();

    // Back-to-back: new start on the final ack.
    req(3, 0, 1, 0);
    ack = 1'b1;
    tick(); tick(); tick();
    chk("t4_ready", 32'(ready), 1);
    sz = 2'd2; ba = 3'd4; mw = 2'd3; bigend = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_at", 32'(at), 4);
    chk("t4_bm", 32'(bm), 8'h0F);
    tick();
    chk("t4_done2", 32'(done), 1);
    chk("t4_idle", 32'(busy), 0);
    ack = 1'b0;
    tick();

    // Stall mid-transfer with a start pending.
    req(3, 0, 1, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    sz = 2'd0; ba = 3'd5; mw = 2'd0; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_at", 32'(at), 2);
      chk("t5_bm", 32'(bm), 8'h0C);
      chk("t5_ncyc", 32'(ncyc), 1);
      chk("t5_ready", 32'(ready), 0);
    end
    start = 1'b0;
    ack = 1'b1;
    tick(); tick(); tick();
    chk("t5_done", 32'(done), 1);
    ack = 1'b0;
    tick();

    // Reset during the second cycle.
    req(3, 0, 1, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_bm", 32'(bm), 0);
    chk("t6_ncyc", 32'(ncyc), 0);
    chk("t6_done", 32'(done), 0);
    tick();
    chk("t6_done_next", 32'(done), 0);
    req(2, 4, 3, 1);
    chk("t6_at", 32'(at), 4);
    chk("t6_bm2", 32'(bm), 8'h0F);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 199) == 0);
      start  = 1'($urandom_range(0, 1));
      sz     = SZW'($urandom);
      ba     = AB'($urandom);
      mw     = SZW'($urandom);
      bigend = 1'($urandom_range(0, 1));
      ack    = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
